regfile_sb: RTL and testbench

Parametrised register file with per-entry scoreboard for the multicycle datapath. It supersedes the fixed 32x32 register file with configurable width and depth, an optional hardwired zero register, write-to-read bypass, and a busy-bit scoreboard for pending multicycle results. It also has a sequential clear engine that zeroes storage one entry per cycle after reset, so the array maps to RAM. It sits between decode (read and claim) and write-back (write).

---
 rtl/regfile_pkg.sv | 12 +
 rtl/rf_scoreboard.sv | 45 ++++
 rtl/regfile_sb.sv | 135 +++++++++++++
 tb/tb_regfile_sb.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the scoreboarded register file.
package regfile_pkg;

  typedef enum logic [0:0] {
    RF_CLEAR,
    RF_RUN
  } rf_state_t;

  localparam int unsigned RF_DATA_W = 32;
  localparam int unsigned RF_ADDR_W = 5;

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard: one flop per entry, set by claim, cleared by write-back.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W = RF_ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              set_en_i,
  input  logic [ADDR_W-1:0] set_addr_i,
  input  logic              clr_en_i,
  input  logic [ADDR_W-1:0] clr_addr_i,
  input  logic [ADDR_W-1:0] rd_addr_a_i,
  input  logic [ADDR_W-1:0] rd_addr_b_i,
  output logic              busy_a_o,
  output logic              busy_b_o
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [Depth-1:0] busy_q, busy_d;

  // Set is applied after clear so a claim on the write-back address wins.
  always_comb begin
    busy_d = busy_q;
    if (clr_en_i) begin
      busy_d[clr_addr_i] = 1'b0;
    end
    if (set_en_i) begin
      busy_d[set_addr_i] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_a_o = busy_q[rd_addr_a_i];
  assign busy_b_o = busy_q[rd_addr_b_i];

endmodule

// File: rtl/regfile_sb.sv
// Parametrised register file with write bypass, busy scoreboard and a
// post-reset clear engine that zeroes one entry per cycle.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = RF_DATA_W,
  parameter int unsigned ADDR_W   = RF_ADDR_W,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic [ADDR_W-1:0] rd_addr_a_i,
  input  logic [ADDR_W-1:0] rd_addr_b_i,
  output logic [DATA_W-1:0] rd_data_a_o,
  output logic [DATA_W-1:0] rd_data_b_o,
  output logic              rd_busy_a_o,
  output logic              rd_busy_b_o,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              claim_en_i,
  input  logic [ADDR_W-1:0] claim_addr_i,
  output logic              ready_o
);

  localparam int unsigned       Depth    = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(Depth - 1);

  rf_state_t         state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic              ready;

  logic [DATA_W-1:0] mem_q [Depth];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  logic              wr_ok, claim_ok;
  logic [1:0][ADDR_W-1:0] rd_addr;
  logic [1:0][DATA_W-1:0] rd_data;
  logic [1:0]             rd_busy, sb_busy;

  function automatic logic is_zero(input logic [ADDR_W-1:0] addr);
    return ZERO_REG && (addr == '0);
  endfunction

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    case (state_q)
      RF_CLEAR: begin
        clr_ptr_d = clr_ptr_q + ADDR_W'(1);
        if (clr_ptr_q == LastAddr) begin
          state_d = RF_RUN;
        end
      end
      RF_RUN:  state_d = RF_RUN;
      default: state_d = RF_CLEAR;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q   <= RF_CLEAR;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  assign ready    = (state_q == RF_RUN);
  assign ready_o  = ready;
  assign wr_ok    = ready && wr_en_i && !is_zero(wr_addr_i);
  assign claim_ok = ready && claim_en_i && !is_zero(claim_addr_i);

  // Single storage write port shared by the clear engine and write-back.
  always_comb begin
    mem_we    = wr_ok;
    mem_waddr = wr_addr_i;
    mem_wdata = wr_data_i;
    if (!ready) begin
      mem_we    = 1'b1;
      mem_waddr = clr_ptr_q;
      mem_wdata = '0;
    end
  end

  // No reset on the array so it can map onto RAM.
  always_ff @(posedge clock_i) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  rf_scoreboard #(
    .ADDR_W(ADDR_W)
  ) u_scoreboard (
    .clk_i      (clock_i),
    .rst_i      (reset_i),
    .set_en_i   (claim_ok),
    .set_addr_i (claim_addr_i),
    .clr_en_i   (wr_ok),
    .clr_addr_i (wr_addr_i),
    .rd_addr_a_i(rd_addr_a_i),
    .rd_addr_b_i(rd_addr_b_i),
    .busy_a_o   (sb_busy[0]),
    .busy_b_o   (sb_busy[1])
  );

  assign rd_addr[0] = rd_addr_a_i;
  assign rd_addr[1] = rd_addr_b_i;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_data[p] = '0;
      rd_busy[p] = 1'b0;
      if (ready && !is_zero(rd_addr[p])) begin
        if (wr_en_i && (wr_addr_i == rd_addr[p])) begin
          rd_data[p] = wr_data_i;
          rd_busy[p] = claim_en_i && (claim_addr_i == rd_addr[p]);
        end else begin
          rd_data[p] = mem_q[rd_addr[p]];
          rd_busy[p] = sb_busy[p];
        end
      end
    end
  end

  assign rd_data_a_o = rd_data[0];
  assign rd_data_b_o = rd_data[1];
  assign rd_busy_a_o = rd_busy[0];
  assign rd_busy_b_o = rd_busy[1];

endmodule

// File: tb/tb_regfile_sb.sv
// Drives a ZERO_REG=0 and a ZERO_REG=1 instance with shared stimulus and
// compares both against an array-based reference model every cycle.
module tb_regfile_sb;

  localparam int unsigned Depth = 32;

  logic        clock;
  logic        reset;
  logic        wr_en, claim_en;
  logic [4:0]  rd_addr_a, rd_addr_b, wr_addr, claim_addr;
  logic [31:0] wr_data;

  logic [31:0] data_a [2];
  logic [31:0] data_b [2];
  logic        busy_a [2];
  logic        busy_b [2];
  logic        ready  [2];

  int n_checks = 0;
  int n_errors = 0;

  // Reference model, index 0 = ZERO_REG off, 1 = ZERO_REG on.
  logic [31:0] mem_m  [2][Depth];
  bit          busy_m [2][Depth];
  int          clear_left = 0;
  bit          known = 0;

  regfile_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b0)) u_dut_nz (
    .clock_i     (clock),
    .reset_i     (reset),
    .rd_addr_a_i (rd_addr_a),
    .rd_addr_b_i (rd_addr_b),
    .rd_data_a_o (data_a[0]),
    .rd_data_b_o (data_b[0]),
    .rd_busy_a_o (busy_a[0]),
    .rd_busy_b_o (busy_b[0]),
    .wr_en_i     (wr_en),
    .wr_addr_i   (wr_addr),
    .wr_data_i   (wr_data),
    .claim_en_i  (claim_en),
    .claim_addr_i(claim_addr),
    .ready_o     (ready[0])
  );

  regfile_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1)) u_dut_z (
    .clock_i     (clock),
    .reset_i     (reset),
    .rd_addr_a_i (rd_addr_a),
    .rd_addr_b_i (rd_addr_b),
    .rd_data_a_o (data_a[1]),
    .rd_data_b_o (data_b[1]),
    .rd_busy_a_o (busy_a[1]),
    .rd_busy_b_o (busy_b[1]),
    .wr_en_i     (wr_en),
    .wr_addr_i   (wr_addr),
    .wr_data_i   (wr_data),
    .claim_en_i  (claim_en),
    .claim_addr_i(claim_addr),
    .ready_o     (ready[1])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit model_ready();
    return known && (clear_left == 0);
  endfunction

  function automatic bit dropped(input int z, input logic [4:0] a);
    return (z == 1) && (a == 5'd0);
  endfunction

  function automatic logic [31:0] exp_data(input int z, input logic [4:0] a);
    if (!model_ready() || dropped(z, a)) return 32'h0;
    if (wr_en && wr_addr == a) return wr_data;
    return mem_m[z][a];
  endfunction

  function automatic logic exp_busy(input int z, input logic [4:0] a);
    if (!model_ready() || dropped(z, a)) return 1'b0;
    if (wr_en && wr_addr == a) return claim_en && (claim_addr == a);
    return busy_m[z][a];
  endfunction

  task automatic check_outputs();
    if (known) begin
      for (int z = 0; z < 2; z++) begin
        check_val($sformatf("ready[z%0d]", z), {31'b0, ready[z]}, {31'b0, model_ready()});
        check_val($sformatf("data_a[z%0d] @%0d", z, rd_addr_a), data_a[z], exp_data(z, rd_addr_a));
        check_val($sformatf("data_b[z%0d] @%0d", z, rd_addr_b), data_b[z], exp_data(z, rd_addr_b));
        check_val($sformatf("busy_a[z%0d] @%0d", z, rd_addr_a), {31'b0, busy_a[z]},
                  {31'b0, exp_busy(z, rd_addr_a)});
        check_val($sformatf("busy_b[z%0d] @%0d", z, rd_addr_b), {31'b0, busy_b[z]},
                  {31'b0, exp_busy(z, rd_addr_b)});
      end
    end
  endtask

  task automatic update_model();
    if (reset) begin
      known      = 1'b1;
      clear_left = Depth;
      for (int z = 0; z < 2; z++) begin
        for (int i = 0; i < Depth; i++) begin
          mem_m[z][i]  = 32'h0;
          busy_m[z][i] = 1'b0;
        end
      end
    end else if (known && clear_left > 0) begin
      clear_left--;
    end else if (known) begin
      for (int z = 0; z < 2; z++) begin
        if (wr_en && !dropped(z, wr_addr)) begin
          mem_m[z][wr_addr]  = wr_data;
          busy_m[z][wr_addr] = 1'b0;
        end
        if (claim_en && !dropped(z, claim_addr)) busy_m[z][claim_addr] = 1'b1;
      end
    end
  endtask

  // Inputs already applied; check mid-cycle, then cross one rising edge.
  task automatic tick();
    #2;
    check_outputs();
    @(posedge clock);
    update_model();
    #1;
  endtask

  task automatic drive(input logic rst, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic ce, input logic [4:0] ca,
                       input logic [4:0] ra, input logic [4:0] rb);
    reset      = rst;
    wr_en      = we;
    wr_addr    = wa;
    wr_data    = wd;
    claim_en   = ce;
    claim_addr = ca;
    rd_addr_a  = ra;
    rd_addr_b  = rb;
  endtask

  task automatic wait_ready(input string tag);
    int low_cnt = 0;
    for (int c = 0; c < 40 && !ready[1]; c++) begin
      drive(1'b0, c == 3, 5'd5, 32'hDEAD_BEEF, c == 4, 5'd6, 5'd5, 5'd6);
      tick();
      low_cnt++;
    end
    check_val(tag, low_cnt, 32);
  endtask

  initial begin
    drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
    repeat (3) tick();
    wait_ready("ready_low_after_reset");

    for (int i = 0; i < Depth; i++) begin
      drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'(i), 5'(31 - i));
      tick();
    end

    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd6);
    #1;
    check_val("clear_write_ignored", data_a[0], 32'h0);
    check_val("clear_claim_ignored", {31'b0, busy_b[0]}, 32'h0);
    tick();

    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd7, 5'd7);
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd7);
    #1;
    check_val("claim_visible", {31'b0, busy_a[0]}, 32'h1);
    tick();
    drive(1'b0, 1'b1, 5'd7, 32'h1234_5678, 1'b0, 5'd0, 5'd7, 5'd7);
    #1;
    check_val("bypass_data", data_b[0], 32'h1234_5678);
    check_val("bypass_busy", {31'b0, busy_b[0]}, 32'h0);
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd7);
    #1;
    check_val("busy_cleared", {31'b0, busy_a[0]}, 32'h0);
    tick();

    drive(1'b0, 1'b1, 5'd9, 32'hA5A5_A5A5, 1'b1, 5'd9, 5'd9, 5'd9);
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd9);
    #1;
    check_val("claim_write_data", data_a[0], 32'hA5A5_A5A5);
    check_val("claim_wins_busy", {31'b0, busy_a[0]}, 32'h1);
    tick();

    drive(1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 5'd1, 5'd1);
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
    #1;
    check_val("zero_reg_data", data_a[1], 32'h0);
    check_val("zero_reg_busy", {31'b0, busy_a[1]}, 32'h0);
    check_val("nonzero_reg0_data", data_a[0], 32'hFFFF_FFFF);
    tick();

    drive(1'b0, 1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 5'd3, 5'd4);
    tick();
    drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd4);
    tick();
    wait_ready("ready_low_after_midrun_reset");
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd4);
    #1;
    check_val("reset_clears_data", data_a[0], 32'h0);
    check_val("reset_clears_busy", {31'b0, busy_b[0]}, 32'h0);
    tick();

    for (int n = 0; n < 3000; n++) begin
      logic [4:0] wa, ca, ra, rb;
      wa = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      ca = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom);
      ra = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ra : 5'($urandom);
      drive($urandom_range(0, 399) == 0, $urandom_range(0, 1) == 1, wa, $urandom,
            $urandom_range(0, 2) == 0, ca, ra, rb);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
